// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART core: turns rx_done rising edges into pushes
// into a first-word-fall-through FIFO, with overrun, threshold and idle-timeout status.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_done_i,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          overrun_o,
    input  logic          clr_overrun_i,
    input  logic [AW:0]   thresh_i,
    output logic          thresh_irq_o,
    input  logic [15:0]   timeout_cycles_i,
    output logic          timeout_irq_o,
    input  logic          clr_timeout_i
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          done_q;
    logic [15:0]   idle_cnt;
    logic          push, pop, wr, ov_set, to_set, to_en;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign count_o = count;

    assign push   = rx_done_i & ~done_q;
    assign pop    = rd_en_i & ~empty_o;
    // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
    assign wr     = push & (~full_o | pop);
    assign ov_set = push & full_o & ~pop;
    assign to_en  = (timeout_cycles_i != 16'd0);
    assign to_set = to_en && (idle_cnt == timeout_cycles_i) && !empty_o;

    assign rd_data_o    = empty_o ? 8'h00 : mem[rp];
    assign thresh_irq_o = (thresh_i != '0) && (count >= thresh_i);

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr)
            mem[wp] <= rx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            done_q        <= 1'b1;
            idle_cnt      <= 16'd0;
            overrun_o     <= 1'b0;
            timeout_irq_o <= 1'b0;
        end else begin
            done_q <= rx_done_i;
            if (wr)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (wr && !pop)
                count <= count + 1'b1;
            else if (pop && !wr)
                count <= count - 1'b1;

            if (ov_set)
                overrun_o <= 1'b1;
            else if (clr_overrun_i)
                overrun_o <= 1'b0;

            // Clamp rather than hold so a lowered timeout compares immediately.
            if (push || pop || empty_o || !to_en)
                idle_cnt <= 16'd0;
            else if (idle_cnt >= timeout_cycles_i)
                idle_cnt <= timeout_cycles_i;
            else
                idle_cnt <= idle_cnt + 16'd1;

            if (to_set)
                timeout_irq_o <= 1'b1;
            else if (pop || clr_timeout_i)
                timeout_irq_o <= 1'b0;
        end
    end

endmodule
